rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 14 +
 rtl/rom_arb_tag_pipe.sv | 37 +++
 rtl/rom_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter: response owner encoding and parameter limits.
package rom_arbiter_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int ROM_LAT_MIN    = 1;
  localparam int ROM_LAT_MAX    = 4;
  localparam int STARVE_MAX_LIM = 15;
  localparam int STARVE_W       = 4;

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Valid/owner shift pipeline: tags each ROM read with its requester so the response
// can be steered back exactly DEPTH cycles after the grant.
module rom_arb_tag_pipe
  import rom_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld_i,
  input  logic in_own_i,
  output logic out_vld_o,
  output logic out_own_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] own_q;

  // Shift the tag one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      own_q[0] <= in_own_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign out_vld_o = vld_q[DEPTH-1];
  assign out_own_o = own_q[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port ROM.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is ls priority with a fetch starvation guard.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic if_gnt_s;
  logic ls_gnt_s;
  logic pipe_vld_s;
  logic pipe_own_s;

`ifdef ROM_ARB_RR_EN
  owner_e last_q;
  owner_e last_d;

  // Contention goes to whichever requester was not granted most recently.
  always_comb begin
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (rst) begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end else if (if_req && ls_req) begin
      if (last_q == OWN_IF) begin
        ls_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b1;
      end
    end else begin
      if_gnt_s = if_req;
      ls_gnt_s = ls_req;
    end
  end

  // Remember the most recent winner of any grant.
  always_comb begin
    last_d = last_q;
    if (if_gnt_s) begin
      last_d = OWN_IF;
    end else if (ls_gnt_s) begin
      last_d = OWN_LS;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer resets as if ls just won, so fetch wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_LS;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  // Load-store wins contention until fetch has been refused STARVE_MAX cycles in a row.
  always_comb begin
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (rst) begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end else if (if_req && ls_req) begin
      if (starve_q == STARVE_W'(STARVE_MAX)) begin
        if_gnt_s = 1'b1;
      end else begin
        ls_gnt_s = 1'b1;
      end
    end else begin
      if_gnt_s = if_req;
      ls_gnt_s = ls_req;
    end
  end

  // Count refused fetch cycles, saturating at the limit.
  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt_s) begin
      if (starve_q == STARVE_W'(STARVE_MAX)) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end else begin
      starve_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  assign if_gnt   = if_gnt_s;
  assign ls_gnt   = ls_gnt_s;
  assign rom_en   = if_gnt_s | ls_gnt_s;
  assign rom_addr = if_gnt_s ? if_addr : (ls_gnt_s ? ls_addr : '0);

  rom_arb_tag_pipe #(
    .DEPTH (ROM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (if_gnt_s | ls_gnt_s),
    .in_own_i  (ls_gnt_s),
    .out_vld_o (pipe_vld_s),
    .out_own_o (pipe_own_s)
  );

  // Stale pipeline contents are still visible during the reset cycle itself, hence the rst gating.
  assign if_rvalid = !rst && pipe_vld_s && (pipe_own_s == OWN_IF);
  assign ls_rvalid = !rst && pipe_vld_s && (pipe_own_s == OWN_LS);
  assign if_rdata  = if_rvalid ? rom_data : '0;
  assign ls_rdata  = ls_rvalid ? rom_data : '0;

endmodule
